// File: rtl/frogger_pkg.sv
// Shared types, grid constants and helpers for the frogger game blocks.
// The frog sprite generator uses facing_t, so its encoding must stay fixed.
package frogger_pkg;

  localparam int unsigned COORD_W       = 10;
  localparam int unsigned CELL_PX       = 32;
  localparam int unsigned HOP_STEP_PX   = 4;
  localparam int unsigned SPAWN_X       = 288;
  localparam int unsigned SPAWN_Y       = 448;
  localparam int unsigned SCREEN_MAX_X  = 608;
  localparam int unsigned SCREEN_MAX_Y  = 448;
  localparam int unsigned RESPAWN_TICKS = 60;

  localparam logic [11:0] COL_FROG  = 12'h2E2;
  localparam logic [11:0] COL_WATER = 12'h11A;
  localparam logic [11:0] COL_ROAD  = 12'h222;
  localparam logic [11:0] COL_GRASS = 12'h4A2;

  typedef enum logic [1:0] {
    FACE_UP    = 2'b00,
    FACE_DOWN  = 2'b01,
    FACE_LEFT  = 2'b10,
    FACE_RIGHT = 2'b11
  } facing_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOP  = 2'd1,
    DEAD = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } frog_pos_t;

  // Request bit index equals the facing code; lower index wins.
  function automatic logic [3:0] prio_onehot(input logic [3:0] e);
    if (e[0])      return 4'b0001;
    else if (e[1]) return 4'b0010;
    else if (e[2]) return 4'b0100;
    else if (e[3]) return 4'b1000;
    else           return 4'b0000;
  endfunction

  function automatic frog_pos_t step_pos(input frog_pos_t p, input facing_t f,
                                         input logic [COORD_W-1:0] d);
    frog_pos_t r;
    r = p;
    case (f)
      FACE_UP:    r.y = p.y - d;
      FACE_DOWN:  r.y = p.y + d;
      FACE_LEFT:  r.x = p.x - d;
      FACE_RIGHT: r.x = p.x + d;
      default:    r = p;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw button followed by a rising-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise_c
);

  // [0] metastable stage, [1] synchronized level, [2] previous level
  logic [2:0] sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sh <= 3'b000;
    else       sh <= {sh[1:0], btn};
  end

  assign rise_c = sh[1] & ~sh[2];

endmodule

// File: rtl/frog_ctrl.sv
// Frog motion controller: button requests to grid-aligned hops, one step per
// video frame, with death/respawn handling. All outputs are registered.
module frog_ctrl
  import frogger_pkg::*;
#(
  parameter int unsigned FROG_SIZE      = CELL_PX,
  parameter int unsigned STEP_PX        = HOP_STEP_PX,
  parameter int unsigned START_X        = SPAWN_X,
  parameter int unsigned START_Y        = SPAWN_Y,
  parameter int unsigned MAX_X          = SCREEN_MAX_X,
  parameter int unsigned MAX_Y          = SCREEN_MAX_Y,
  parameter int unsigned RESPAWN_FRAMES = RESPAWN_TICKS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               kill,
  output logic [COORD_W-1:0] frog_x,
  output logic [COORD_W-1:0] frog_y,
  output logic [1:0]         facing,
  output logic               hopping,
  output logic               hop_done,
  output logic               dead
);

  localparam int unsigned STEPS  = FROG_SIZE / STEP_PX;
  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned DEAD_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;

  ctrl_state_t        state, state_d;
  logic [3:0]         req, req_d;
  logic [STEP_W-1:0]  step_cnt, step_d;
  logic [DEAD_W-1:0]  dead_cnt, dcnt_d;
  logic [COORD_W-1:0] x_d, y_d;
  facing_t            facing_d, req_dir, mv_dir;
  logic               hop_done_d, legal;
  logic [3:0]         btn_raw, edge_c;
  frog_pos_t          mv_pos;

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_sync_edge u_btn (
      .clk    (clk),
      .reset  (reset),
      .btn    (btn_raw[i]),
      .rise_c (edge_c[i])
    );
  end

  always_comb begin
    if (req[0])      req_dir = FACE_UP;
    else if (req[1]) req_dir = FACE_DOWN;
    else if (req[2]) req_dir = FACE_LEFT;
    else             req_dir = FACE_RIGHT;
  end

  // Target-cell bounds check on the aligned position, before any subtraction
  always_comb begin
    legal = 1'b0;
    case (req_dir)
      FACE_UP:    legal = 32'(frog_y) >= FROG_SIZE;
      FACE_DOWN:  legal = 32'(frog_y) + FROG_SIZE <= MAX_Y;
      FACE_LEFT:  legal = 32'(frog_x) >= FROG_SIZE;
      FACE_RIGHT: legal = 32'(frog_x) + FROG_SIZE <= MAX_X;
      default:    legal = 1'b0;
    endcase
  end

  assign mv_dir = (state == IDLE) ? req_dir : facing_t'(facing);
  assign mv_pos = step_pos('{x: frog_x, y: frog_y}, mv_dir, COORD_W'(STEP_PX));

  always_comb begin
    state_d    = state;
    req_d      = req;
    step_d     = step_cnt;
    dcnt_d     = dead_cnt;
    x_d        = frog_x;
    y_d        = frog_y;
    facing_d   = facing_t'(facing);
    hop_done_d = 1'b0;

    case (state)
      IDLE: begin
        if (|edge_c)         req_d = prio_onehot(edge_c);
        else if (frame_tick) req_d = 4'b0000;
        if (frame_tick && (|req)) begin
          facing_d = req_dir;
          if (legal) begin
            state_d = HOP;
            x_d     = mv_pos.x;
            y_d     = mv_pos.y;
            step_d  = STEP_W'(1);
          end
        end
      end
      HOP: begin
        req_d = 4'b0000;
        if (frame_tick) begin
          x_d = mv_pos.x;
          y_d = mv_pos.y;
          if (step_cnt == STEP_W'(STEPS - 1)) begin
            state_d    = IDLE;
            step_d     = '0;
            hop_done_d = 1'b1;
          end else begin
            step_d = step_cnt + STEP_W'(1);
          end
        end
      end
      DEAD: begin
        req_d = 4'b0000;
        if (frame_tick) begin
          if (dead_cnt == DEAD_W'(RESPAWN_FRAMES - 1)) begin
            state_d  = IDLE;
            dcnt_d   = '0;
            x_d      = COORD_W'(START_X);
            y_d      = COORD_W'(START_Y);
            facing_d = FACE_UP;
          end else begin
            dcnt_d = dead_cnt + DEAD_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Kill overrides any same-cycle tick; already dead means no restart
    if (kill && (state != DEAD)) begin
      state_d    = DEAD;
      req_d      = 4'b0000;
      step_d     = '0;
      dcnt_d     = '0;
      x_d        = frog_x;
      y_d        = frog_y;
      facing_d   = facing_t'(facing);
      hop_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      req      <= 4'b0000;
      step_cnt <= '0;
      dead_cnt <= '0;
      frog_x   <= COORD_W'(START_X);
      frog_y   <= COORD_W'(START_Y);
      facing   <= FACE_UP;
      hopping  <= 1'b0;
      hop_done <= 1'b0;
      dead     <= 1'b0;
    end else begin
      state    <= state_d;
      req      <= req_d;
      step_cnt <= step_d;
      dead_cnt <= dcnt_d;
      frog_x   <= x_d;
      frog_y   <= y_d;
      facing   <= facing_d;
      hopping  <= (state_d == HOP);
      hop_done <= hop_done_d;
      dead     <= (state_d == DEAD);
    end
  end

endmodule

// File: tb/tb_frog_ctrl.sv
// Directed self-checking bench for frog_ctrl with hand-computed positions.
module tb_frog_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       kill = 1'b0;
  logic [9:0] frog_x, frog_y;
  logic [1:0] facing;
  logic       hopping, hop_done, dead;

  int vecs = 0;
  int errs = 0;
  int done_cnt = 0;

  frog_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .kill       (kill),
    .frog_x     (frog_x),
    .frog_y     (frog_y),
    .facing     (facing),
    .hopping    (hopping),
    .hop_done   (hop_done),
    .dead       (dead)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (hop_done) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the tick edge.
  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    cyc(4);
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    cyc(4);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    do_reset();
    if (frog_x !== 10'd288) begin $display("FAIL reset_x got %0d want 288", frog_x); errs++; end vecs++;
    if (frog_y !== 10'd448) begin $display("FAIL reset_y got %0d want 448", frog_y); errs++; end vecs++;
    if (facing !== 2'b00) begin $display("FAIL reset_facing got %b want 00", facing); errs++; end vecs++;
    if ({hopping, hop_done, dead} !== 3'b000) begin
      $display("FAIL reset_flags got %b want 000", {hopping, hop_done, dead}); errs++;
    end vecs++;
  endtask

  task automatic test_up_hop();
    done_cnt = 0;
    press(1, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (frog_y !== 10'(448 - 4 * k)) begin
        $display("FAIL up_y tick %0d got %0d want %0d", k, frog_y, 448 - 4 * k); errs++;
      end vecs++;
      if (hopping !== (k < 8)) begin
        $display("FAIL up_hopping tick %0d got %b want %b", k, hopping, (k < 8)); errs++;
      end vecs++;
    end
    if (hop_done !== 1'b1) begin $display("FAIL up_hop_done got %b want 1", hop_done); errs++; end vecs++;
    if (frog_x !== 10'd288) begin $display("FAIL up_x got %0d want 288", frog_x); errs++; end vecs++;
    if (facing !== 2'b00) begin $display("FAIL up_facing got %b want 00", facing); errs++; end vecs++;
    cyc(2);
    if (done_cnt !== 1) begin $display("FAIL up_done_count got %0d want 1", done_cnt); errs++; end vecs++;
  endtask

  task automatic test_blocked();
    do_reset();
    done_cnt = 0;
    press(0, 1, 0, 0);
    tick();
    if (facing !== 2'b01) begin $display("FAIL blocked_facing got %b want 01", facing); errs++; end vecs++;
    if (frog_y !== 10'd448) begin $display("FAIL blocked_y got %0d want 448", frog_y); errs++; end vecs++;
    if (hopping !== 1'b0) begin $display("FAIL blocked_hopping got %b want 0", hopping); errs++; end vecs++;
    cyc(3);
    if (done_cnt !== 0) begin $display("FAIL blocked_done_count got %0d want 0", done_cnt); errs++; end vecs++;
  endtask

  task automatic test_press_during_hop();
    do_reset();
    press(1, 0, 0, 0);
    tick();
    tick();
    btn_left = 1'b1;
    for (int k = 3; k <= 8; k++) tick();
    btn_left = 1'b0;
    if (frog_y !== 10'd416) begin $display("FAIL dur_y got %0d want 416", frog_y); errs++; end vecs++;
    if (frog_x !== 10'd288) begin $display("FAIL dur_x got %0d want 288", frog_x); errs++; end vecs++;
    cyc(4);
    tick();
    tick();
    if (frog_x !== 10'd288) begin $display("FAIL dur_noqueue_x got %0d want 288", frog_x); errs++; end vecs++;
    if ({hopping, facing} !== 3'b000) begin
      $display("FAIL dur_noqueue_state got %b want 000", {hopping, facing}); errs++;
    end vecs++;
  endtask

  task automatic test_simultaneous();
    press(1, 0, 0, 1);
    tick();
    if (facing !== 2'b00) begin $display("FAIL simul_facing got %b want 00", facing); errs++; end vecs++;
    if (frog_y !== 10'd412) begin $display("FAIL simul_y got %0d want 412", frog_y); errs++; end vecs++;
    repeat (7) tick();
    if ({frog_x, frog_y} !== {10'd288, 10'd384}) begin
      $display("FAIL simul_end got (%0d,%0d) want (288,384)", frog_x, frog_y); errs++;
    end vecs++;
  endtask

  task automatic test_kill_mid_hop();
    do_reset();
    press(1, 0, 0, 0);
    repeat (3) tick();
    if (frog_y !== 10'd436) begin $display("FAIL kill_pre_y got %0d want 436", frog_y); errs++; end vecs++;
    kill = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    frame_tick = 1'b0;
    if ({dead, hopping, hop_done} !== 3'b100) begin
      $display("FAIL kill_flags got %b want 100", {dead, hopping, hop_done}); errs++;
    end vecs++;
    if (frog_y !== 10'd436) begin $display("FAIL kill_frozen_y got %0d want 436", frog_y); errs++; end vecs++;
    repeat (59) tick();
    if ({dead, frog_y} !== {1'b1, 10'd436}) begin
      $display("FAIL kill_59 got dead=%b y=%0d want dead=1 y=436", dead, frog_y); errs++;
    end vecs++;
    tick();
    if ({frog_x, frog_y, facing, dead} !== {10'd288, 10'd448, 2'b00, 1'b0}) begin
      $display("FAIL kill_respawn got (%0d,%0d,%b) dead=%b want (288,448,00) dead=0",
               frog_x, frog_y, facing, dead); errs++;
    end vecs++;
  endtask

  task automatic test_kill_idle_rekill();
    press(0, 0, 0, 1);
    repeat (8) tick();
    if ({frog_x, facing} !== {10'd320, 2'b11}) begin
      $display("FAIL right_hop got x=%0d facing=%b want x=320 facing=11", frog_x, facing); errs++;
    end vecs++;
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    if ({dead, frog_x} !== {1'b1, 10'd320}) begin
      $display("FAIL idle_kill got dead=%b x=%0d want dead=1 x=320", dead, frog_x); errs++;
    end vecs++;
    repeat (30) tick();
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    repeat (29) tick();
    if (dead !== 1'b1) begin $display("FAIL rekill_59 got dead=%b want 1", dead); errs++; end vecs++;
    tick();
    if ({frog_x, frog_y, facing, dead} !== {10'd288, 10'd448, 2'b00, 1'b0}) begin
      $display("FAIL rekill_respawn got (%0d,%0d,%b) dead=%b want (288,448,00) dead=0",
               frog_x, frog_y, facing, dead); errs++;
    end vecs++;
  endtask

  task automatic test_reset_mid_hop();
    press(0, 0, 1, 0);
    repeat (3) tick();
    if (frog_x !== 10'd276) begin $display("FAIL rst_pre_x got %0d want 276", frog_x); errs++; end vecs++;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    if ({frog_x, frog_y, facing, hopping, dead} !== {10'd288, 10'd448, 2'b00, 1'b0, 1'b0}) begin
      $display("FAIL rst_async got (%0d,%0d,%b) hop=%b dead=%b want (288,448,00) 0 0",
               frog_x, frog_y, facing, hopping, dead); errs++;
    end vecs++;
    @(negedge clk);
    cyc(2);
    reset = 1'b0;
    cyc(1);
    press(1, 0, 0, 0);
    tick();
    if ({frog_y, hopping, facing} !== {10'd444, 1'b1, 2'b00}) begin
      $display("FAIL rst_after got y=%0d hop=%b facing=%b want y=444 hop=1 facing=00",
               frog_y, hopping, facing); errs++;
    end vecs++;
  endtask

  initial begin
    test_reset();
    test_up_hop();
    test_blocked();
    test_press_during_hop();
    test_simultaneous();
    test_kill_mid_hop();
    test_kill_idle_rekill();
    test_reset_mid_hop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/frog_ctrl.md
# frog_ctrl

Frog motion controller that sits directly upstream of the frog sprite generator. Turns raw direction buttons into a grid-aligned frog position, facing code and hop animation, advancing once per video frame. Drives the generator's `frog_x`, `frog_y` and `facing` inputs and reports hop completion and death status to the game-state logic.

## Interface

**Parameters**
- `FROG_SIZE`, 32: sprite and grid cell size in pixels.
- `STEP_PX`, 4: pixels moved per frame during a hop; must divide `FROG_SIZE`.
- `START_X`, 288: spawn x in pixels (column 9).
- `START_Y`, 448: spawn y in pixels (row 14).
- `MAX_X`, 608: largest legal x.
- `MAX_Y`, 448: largest legal y.
- `RESPAWN_FRAMES`, 60: frames spent in DEAD before respawn.

**Ports**
- `clk` in 1: pixel clock.
- `reset` in 1: asynchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per frame, at vblank start.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: raw, asynchronous, active-high.
- `kill` in 1: collision or drowning, sampled every cycle.
- `frog_x` out 10: top-left x of the sprite.
- `frog_y` out 10: top-left y of the sprite.
- `facing` out 2: 00 up, 01 down, 10 left, 11 right.
- `hopping` out 1: high while in HOP.
- `hop_done` out 1: one-cycle pulse when a hop lands.
- `dead` out 1: high while in DEAD.

## Operation

**Reset values**
- `frog_x` = START_X, `frog_y` = START_Y, `facing` = 00.
- `hopping`, `hop_done`, `dead` = 0.
- State IDLE; all requests and counters cleared.

**Buttons**
- Each button passes through a 2-flop synchronizer, then a rising-edge detector.
- A detected edge sets a one-hot pending request latch.
- Priority when several edges arrive together: up > down > left > right. A later edge overwrites the pending latch.
- The latch clears when consumed by a frame tick.
- Edges arriving in HOP or DEAD are discarded, and the latch is cleared. Hops are never queued.

**States**
- **IDLE.** On `frame_tick` with a request pending:
  - `facing` is set to the request direction.
  - If the target cell is legal, go to HOP. Legal means x in 0..MAX_X and y in 0..MAX_Y.
  - Otherwise stay in IDLE. Facing still changes and position is unchanged.
- **HOP.** Each `frame_tick` moves the frog STEP_PX in the `facing` direction (up = −y, left = −x). A step counter runs 0..FROG_SIZE/STEP_PX−1.
  - The first step is taken on the same tick that accepts the request.
  - After the final step the position is cell-aligned. The block then returns to IDLE and pulses `hop_done` for one cycle.
- **DEAD.** Entered from any state on `kill`=1. `dead`=1 and position is frozen.
  - A frame counter counts RESPAWN_FRAMES ticks.
  - On expiry, position goes to START, `facing`=00, and state returns to IDLE.
  - `kill` while already in DEAD does not restart the counter.

**Arithmetic and precedence**
- Arithmetic is 10-bit unsigned. Legality is checked before the move, so it never wraps.
- `kill` has priority over `frame_tick` in the same cycle. The step is not applied and `hop_done` does not pulse.

## Timing

- Button edge to latched request: 3 cycles (2 synchronizer + 1 edge/latch).
- Request to first movement: the next `frame_tick`. The outputs update the cycle after that tick.
- A hop lasts exactly FROG_SIZE/STEP_PX ticks (8 by default). `hop_done` is asserted the cycle after the 8th tick.
- `kill` to `dead`=1: 1 cycle.
- Reset mid-hop or mid-DEAD returns all outputs to reset values immediately (asynchronous).
- All outputs are registered, with no combinational path from inputs.

## Structure

- `frogger_pkg` holds:
  - `facing_t` enum: FACE_UP=00, FACE_DOWN=01, FACE_LEFT=10, FACE_RIGHT=11. Shared with the sprite generator.
  - `ctrl_state_t` enum: IDLE, HOP, DEAD.
  - Grid constants (cell size, screen bounds, spawn cell).
  - Colour constants.
- Sub-module `btn_sync_edge`: 2-flop synchronizer plus rising-edge pulse, same clock and reset. Instantiated once per button.

## Test plan

- **Reset, then up.** Reset, then pulse `btn_up`, then 8 ticks. `facing`=00, `hopping` for 8 ticks, `frog_y` steps 444, 440 … 416, `frog_x`=288. `hop_done` pulses once.
- **Blocked move.** From spawn, press down. `facing`=01, `frog_y` stays 448, `hopping` stays 0, no `hop_done`.
- **Press during hop.** Press left during tick 3 of an up hop. The left press is ignored: `frog_x` stays 288 and the hop ends at y=416.
- **Simultaneous buttons.** Assert right and up on the same cycle. `facing`=00 and the frog moves up.
- **Kill mid-hop.** Assert `kill` at tick 4 with `frame_tick` also high. Position frozen at y=436, `dead`=1. After 60 ticks the frog is at (288,448), `facing`=00, `dead`=0.
- **Reset mid-hop.** Assert `reset` mid-hop. Outputs return to (288,448,00) immediately. The first press after release is accepted normally.
